mem_access_unit: RTL

Data-memory access stage that sits directly downstream of the execute stage. It accepts one load or store request per handshake, drives a req/gnt/rvalid data-bus transaction with word-aligned address and byte enables, and aligns and extends load data. Load results go to writeback as a one-cycle pulse. The pipeline is stalled through `ex_ready_o` while a transaction is outstanding.

---
 rtl/mem_access_unit.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Data-memory access stage. Accepts one load/store from execute,
//            runs a req/gnt/rvalid bus transaction with word-aligned address,
//            byte enables and lane-replicated store data, then aligns and
//            sign/zero-extends load data into a one-cycle writeback pulse.
// Options  : MEM_MISALIGN_TRAP_EN - when defined, misaligned half/word
//            requests raise misalign_o/fault_addr_o instead of accessing
//            the bus. When undefined, low address bits beyond the access
//            size are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32      // fixed at 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    // execute-side request
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic              ex_we_i,
    input  logic [1:0]        ex_size_i,
    input  logic              ex_unsigned_i,
    input  logic [ADDR_W-1:0] ex_addr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic [4:0]        ex_rd_i,
    // data bus
    output logic              bus_req_o,
    input  logic              bus_gnt_i,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_rvalid_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    // writeback
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    // misalignment report
    output logic              misalign_o,
    output logic [ADDR_W-1:0] fault_addr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;

    logic                ready_q;
    logic                accept;
    logic                misaligned;
    logic                start_bus;
    logic                load_done;

    logic [3:0]          be_calc;
    logic [DATA_W-1:0]   wdata_calc;

    // latched request
    logic                we_q;
    logic [1:0]          size_q;
    logic                unsigned_q;
    logic [1:0]          offset_q;
    logic [4:0]          rd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          be_q;
    logic [DATA_W-1:0]   wdata_q;

    // writeback registers
    logic                wb_valid_q;
    logic [4:0]          wb_rd_q;
    logic [DATA_W-1:0]   wb_data_q;

    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [DATA_W-1:0]   load_data;

    // Detect accesses whose low address bits exceed the access size.
`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        misaligned = 1'b0;
        case (ex_size_i)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = ex_addr_i[0];
            default: misaligned = |ex_addr_i[1:0];
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    assign accept    = ex_valid_i & ready_q;
    assign start_bus = accept & ~misaligned;
    assign load_done = (state == RESP) & bus_rvalid_i & ~we_q;

    // Byte enables and lane-replicated store data for the incoming request.
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = ex_wdata_i;
        case (ex_size_i)
            2'b00: begin
                be_calc    = 4'b0001 << ex_addr_i[1:0];
                wdata_calc = {4{ex_wdata_i[7:0]}};
            end
            2'b01: begin
                be_calc    = ex_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{ex_wdata_i[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = ex_wdata_i;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic; rvalid only counts while waiting in RESP.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_bus)    next_state = REQ;
            REQ:     if (bus_gnt_i)    next_state = RESP;
            RESP:    if (bus_rvalid_i) next_state = IDLE;
            default:                   next_state = IDLE;
        endcase
    end

    // Ready is registered so it reads 0 during reset and 1 once clocked.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= (next_state == IDLE);
        end
    end

    // Capture the request; bus outputs stay stable until the next access.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            offset_q   <= 2'b00;
            rd_q       <= 5'd0;
            addr_q     <= '0;
            be_q       <= 4'b0000;
            wdata_q    <= '0;
        end else if (start_bus) begin
            we_q       <= ex_we_i;
            size_q     <= ex_size_i;
            unsigned_q <= ex_unsigned_i;
            offset_q   <= ex_addr_i[1:0];
            rd_q       <= ex_rd_i;
            addr_q     <= {ex_addr_i[ADDR_W-1:2], 2'b00};
            be_q       <= be_calc;
            wdata_q    <= wdata_calc;
        end
    end

    assign bus_req_o   = (state == REQ);
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_be_o    = be_q;
    assign bus_wdata_o = wdata_q;
    assign ex_ready_o  = ready_q;

    // Select the addressed lane from read data and extend it.
    always_comb begin
        byte_sel = bus_rdata_i[7:0];
        case (offset_q)
            2'd0: byte_sel = bus_rdata_i[7:0];
            2'd1: byte_sel = bus_rdata_i[15:8];
            2'd2: byte_sel = bus_rdata_i[23:16];
            2'd3: byte_sel = bus_rdata_i[31:24];
            default: byte_sel = bus_rdata_i[7:0];
        endcase
        half_sel  = offset_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        load_data = bus_rdata_i;
        case (size_q)
            2'b00:   load_data = {{24{~unsigned_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{16{~unsigned_q & half_sel[15]}}, half_sel};
            default: load_data = bus_rdata_i;
        endcase
    end

    // Writeback pulse; data and register hold between load completions.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= load_done;
            if (load_done) begin
                wb_rd_q   <= rd_q;
                wb_data_q <= load_data;
            end
        end
    end

    assign wb_valid_o = wb_valid_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_data_o  = wb_data_q;

`ifdef MEM_MISALIGN_TRAP_EN
    logic              misalign_q;
    logic [ADDR_W-1:0] fault_addr_q;

    // One-cycle trap pulse carrying the offending byte address.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            misalign_q   <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            misalign_q <= accept & misaligned;
            if (accept & misaligned) begin
                fault_addr_q <= ex_addr_i;
            end
        end
    end

    assign misalign_o   = misalign_q;
    assign fault_addr_o = fault_addr_q;
`else
    assign misalign_o   = 1'b0;
    assign fault_addr_o = '0;
`endif

endmodule
`default_nettype wire
